rx_fsrc_ctrl: RTL and testbench
===============================

// Module: rx_fsrc_ctrl
// PURPOSE
//  Receive-side sequencer for FSRC; the counterpart of the TX FSRC sequencer.
//  - Arms on a regmap or external start, then counts sysref_int pulses.
//  - Opens and closes the RX capture window (rx_data_start / rx_data_en) at
//    programmed SYSREF indices, and emits stretched per-channel triggers.
//  - Sits between the FSRC regmap and the RX datapath.
// PARAMETERS
//  COUNTER_WIDTH     4  width of the SYSREF index counter and all *_cnt inputs
//  NUM_TRIG          4  number of trigger outputs
//  TRIG_PULSE_WIDTH  4  trig_out high time in clk cycles (>=1)
// PORTS
//  clk              in   1                  single clock for all logic
//  resetn           in   1                  async assert, active-low reset
//  sysref_int       in   1                  1-cycle SYSREF strobe, clk domain
//  reg_start        in   1                  1-cycle regmap start pulse
//  seq_trig_in      in   1                  external start level (rising edge used)
//  seq_ext_trig_en  in   1                  1: start = seq_trig_in rise; 0: start = reg_start
//  abort            in   1                  sync abort, level
//  rx_start_cnt     in   COUNTER_WIDTH      SYSREF index that opens the window
//  rx_stop_cnt      in   COUNTER_WIDTH      SYSREF index that closes the window
//  trig_cnt         in   NUM_TRIG x COUNTER_WIDTH  SYSREF index per trigger
//  trig_out         out  NUM_TRIG           stretched trigger pulses
//  rx_data_start    out  1                  1-cycle window-open pulse
//  rx_data_en       out  1                  capture window level
//  busy             out  1                  high in ARM and RUN
//  done             out  1                  1-cycle pulse on normal completion
//  start_err        out  1                  1-cycle pulse: start while busy
//  cfg_err          out  1                  1-cycle pulse: rx_stop_cnt <= rx_start_cnt at start
// BEHAVIOUR
//  - Reset: all outputs 0, FSM = IDLE, count = 0, seq_trig_in_d = 0.
//  - start = seq_ext_trig_en ? (seq_trig_in & ~seq_trig_in_d) : reg_start.
//  - FSM IDLE -> ARM on start with valid config:
//    - *_cnt inputs are latched in that cycle; later input changes have no effect.
//    - busy = 1 from the next cycle.
//    - A sysref_int in the start cycle is ignored.
//  - FSM IDLE, start with rx_stop_cnt <= rx_start_cnt: cfg_err = 1 for the next
//    cycle; FSM stays in IDLE.
//  - ARM -> RUN on first sysref_int; that pulse is index 0, count = 0.
//  - RUN: each sysref_int increments count (index k).
//  - Events: event X fires at index k == X; its output registers 1 clk after
//    the sysref_int cycle.
//  - Index rx_start_cnt: rx_data_start = 1 for one cycle; rx_data_en rises in
//    the same cycle.
//  - Index rx_stop_cnt:
//    - rx_data_en falls; done pulses in the same cycle.
//    - FSM -> IDLE; busy falls in the same cycle.
//  - Index trig_cnt[i]: trig_out[i] high for exactly TRIG_PULSE_WIDTH cycles.
//    - A new fire while already high restarts the stretch.
//    - trig_cnt[i] > rx_stop_cnt never fires.
//  - Events that coincide at the same index all fire in the same cycle; the
//    index-0 events fire on the ARM->RUN sysref.
//  - Start while busy: ignored; start_err pulses 1 cycle later; no state change.
//  - Abort (ARM/RUN):
//    - Next cycle: FSM = IDLE, rx_data_en = 0, trig_out = 0, busy = 0.
//    - done and start_err are not pulsed.
//  - Abort and start in the same cycle: abort wins; start dropped silently,
//    including from IDLE.
//  - Counter never wraps, because rx_stop_cnt <= 2^COUNTER_WIDTH-1 ends RUN first.
//  - resetn asserted mid-sequence: immediate return to the reset state; no done.
// TESTING
//  - reg_start, start=2, stop=5, trig_cnt[0]=3 ->
//    - rx_data_start 1 clk after sysref #2; rx_data_en high from sysref #2+1 to
//      sysref #5+1.
//    - trig_out[0] high 4 cycles after sysref #3; done at sysref #5+1.
//  - start=0, stop=1, trig_cnt=0 on all channels -> rx_data_start and all trig_out
//    fire 1 clk after the first sysref; busy is 0 after sysref #1+1.
//  - seq_ext_trig_en=1, seq_trig_in held high 10 cycles, reg_start toggled ->
//    exactly one sequence starts; reg_start is ignored.
//  - reg_start pulsed again while in RUN -> start_err pulses once; timing of the
//    original sequence is unchanged.
//  - start=4, stop=4 -> cfg_err pulses; busy stays 0; no outputs.
//  - abort at sysref #3 with start=1, stop=6 -> rx_data_en drops next cycle; no done.
//  - Same test with resetn asserted mid-RUN -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/rx_fsrc_ctrl.sv
// rx_fsrc_ctrl: RX FSRC sequencer; arms on start, counts SYSREF pulses and
// drives the capture window and stretched per-channel triggers at programmed indices.
module rx_fsrc_ctrl #(
    parameter int COUNTER_WIDTH    = 4,
    parameter int NUM_TRIG         = 4,
    parameter int TRIG_PULSE_WIDTH = 4
) (
    input  logic                              i_clk,
    input  logic                              i_resetn,
    input  logic                              i_sysref_int,
    input  logic                              i_reg_start,
    input  logic                              i_seq_trig_in,
    input  logic                              i_seq_ext_trig_en,
    input  logic                              i_abort,
    input  logic [COUNTER_WIDTH-1:0]          i_rx_start_cnt,
    input  logic [COUNTER_WIDTH-1:0]          i_rx_stop_cnt,
    input  logic [NUM_TRIG*COUNTER_WIDTH-1:0] i_trig_cnt,
    output logic [NUM_TRIG-1:0]               o_trig_out,
    output logic                              o_rx_data_start,
    output logic                              o_rx_data_en,
    output logic                              o_busy,
    output logic                              o_done,
    output logic                              o_start_err,
    output logic                              o_cfg_err
);
    localparam int TW = $clog2(TRIG_PULSE_WIDTH + 1);
    typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN} state_t;
    state_t                   r_state, w_next;
    logic                     r_trig_in_d;
    logic [COUNTER_WIDTH-1:0] r_cnt;
    logic [COUNTER_WIDTH-1:0] r_start_cnt, r_stop_cnt;
    logic [COUNTER_WIDTH-1:0] r_trig_cnt [NUM_TRIG];
    logic [TW-1:0]            r_tcnt [NUM_TRIG];
    logic                     r_rx_data_start, r_rx_data_en, r_done, r_start_err, r_cfg_err;
    logic                     w_start, w_active, w_cfg_ok, w_go, w_bad_cfg, w_serr, w_evt;
    logic                     w_hit_start, w_hit_stop;
    logic [NUM_TRIG-1:0]      w_hit_trig;
    logic [COUNTER_WIDTH-1:0] w_idx;
    assign w_start   = i_seq_ext_trig_en ? (i_seq_trig_in & ~r_trig_in_d) : i_reg_start;
    assign w_active  = r_state != S_IDLE;
    assign w_cfg_ok  = i_rx_stop_cnt > i_rx_start_cnt;
    // Abort dominates every other request in its cycle, including start from IDLE.
    assign w_go      = w_start & ~w_active & ~i_abort & w_cfg_ok;
    assign w_bad_cfg = w_start & ~w_active & ~i_abort & ~w_cfg_ok;
    assign w_serr    = w_start & w_active & ~i_abort;
    assign w_evt     = i_sysref_int & w_active & ~i_abort;
    assign w_idx     = (r_state == S_ARM) ? '0 : r_cnt + 1'b1;
    assign w_hit_start = w_evt & (w_idx == r_start_cnt);
    assign w_hit_stop  = w_evt & (w_idx == r_stop_cnt);
    always_comb begin
        for (int i = 0; i < NUM_TRIG; i++) begin
            w_hit_trig[i] = w_evt & (w_idx == r_trig_cnt[i]);
            o_trig_out[i] = r_tcnt[i] != '0;
        end
    end
    always_comb begin
        w_next = r_state;
        if (r_state == S_IDLE)
            w_next = w_go ? S_ARM : S_IDLE;
        else if (i_abort || w_hit_stop)
            w_next = S_IDLE;
        else if (r_state == S_ARM && i_sysref_int)
            w_next = S_RUN;
    end
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_trig_in_d     <= 1'b0;
            r_cnt           <= '0;
            r_start_cnt     <= '0;
            r_stop_cnt      <= '0;
            r_rx_data_start <= 1'b0;
            r_rx_data_en    <= 1'b0;
            r_done          <= 1'b0;
            r_start_err     <= 1'b0;
            r_cfg_err       <= 1'b0;
            for (int i = 0; i < NUM_TRIG; i++) begin
                r_trig_cnt[i] <= '0;
                r_tcnt[i]     <= '0;
            end
        end else begin
            r_trig_in_d     <= i_seq_trig_in;
            r_rx_data_start <= w_hit_start;
            r_rx_data_en    <= i_abort ? 1'b0 : w_hit_start ? 1'b1 : w_hit_stop ? 1'b0 : r_rx_data_en;
            r_done          <= w_hit_stop;
            r_start_err     <= w_serr;
            r_cfg_err       <= w_bad_cfg;
            if (w_evt)
                r_cnt <= w_idx;
            if (w_go) begin
                r_start_cnt <= i_rx_start_cnt;
                r_stop_cnt  <= i_rx_stop_cnt;
            end
            for (int i = 0; i < NUM_TRIG; i++) begin
                if (w_go)
                    r_trig_cnt[i] <= i_trig_cnt[i*COUNTER_WIDTH +: COUNTER_WIDTH];
                r_tcnt[i] <= (i_abort && w_active) ? '0 :
                             w_hit_trig[i] ? TW'(TRIG_PULSE_WIDTH) :
                             (r_tcnt[i] != '0) ? r_tcnt[i] - 1'b1 : '0;
            end
        end
    end
    assign o_rx_data_start = r_rx_data_start;
    assign o_rx_data_en    = r_rx_data_en;
    assign o_busy          = w_active;
    assign o_done          = r_done;
    assign o_start_err     = r_start_err;
    assign o_cfg_err       = r_cfg_err;
endmodule

// File: tb/tb_rx_fsrc_ctrl.sv
// tb_rx_fsrc_ctrl: directed checks of rx_fsrc_ctrl with hand-computed output vectors.
// Vector layout: {trig_out[3:0], rx_data_start, rx_data_en, busy, done, start_err, cfg_err}.
module tb_rx_fsrc_ctrl;
    logic        clk = 1'b0, resetn = 1'b0;
    logic        sysref = 1'b0, reg_start = 1'b0, trig_in = 1'b0, ext_en = 1'b0, abort = 1'b0;
    logic [3:0]  start_cnt = '0, stop_cnt = '0;
    logic [15:0] trig_cnt = '0;
    logic [3:0]  trig_out;
    logic        data_start, data_en, busy, done, start_err, cfg_err;
    logic [9:0]  w_out;
    int          n_chk = 0, n_pass = 0;

    rx_fsrc_ctrl dut (
        .i_clk(clk), .i_resetn(resetn), .i_sysref_int(sysref), .i_reg_start(reg_start),
        .i_seq_trig_in(trig_in), .i_seq_ext_trig_en(ext_en), .i_abort(abort),
        .i_rx_start_cnt(start_cnt), .i_rx_stop_cnt(stop_cnt), .i_trig_cnt(trig_cnt),
        .o_trig_out(trig_out), .o_rx_data_start(data_start), .o_rx_data_en(data_en),
        .o_busy(busy), .o_done(done), .o_start_err(start_err), .o_cfg_err(cfg_err)
    );

    always #5 clk = ~clk;
    assign w_out = {trig_out, data_start, data_en, busy, done, start_err, cfg_err};

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", tag, act, exp);
        else n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sref();
        sysref = 1'b1;
        step();
        sysref = 1'b0;
    endtask

    task automatic go();
        reg_start = 1'b1;
        step();
        reg_start = 1'b0;
    endtask

    initial begin
        step(); step();
        chk("reset", 32'(w_out), 32'h000);
        resetn = 1'b1;
        step();
        // start=2 stop=5 trig0=3, other channels beyond stop
        start_cnt = 4'd2; stop_cnt = 4'd5; trig_cnt = 16'hFFF3;
        go();
        chk("t1_arm", 32'(w_out), 32'h008);
        start_cnt = 4'd7; stop_cnt = 4'd9; trig_cnt = 16'h0000;
        step(); step();
        sref(); chk("t1_s0", 32'(w_out), 32'h008);
        step();
        sref(); chk("t1_s1", 32'(w_out), 32'h008);
        sref(); chk("t1_s2_open", 32'(w_out), 32'h038);
        step(); chk("t1_s2_p1", 32'(w_out), 32'h018);
        sref(); chk("t1_s3_trig", 32'(w_out), 32'h058);
        step(); step(); step();
        chk("t1_trig_c4", 32'(w_out), 32'h058);
        step(); chk("t1_trig_c5", 32'(w_out), 32'h018);
        go();   chk("t1_start_err", 32'(w_out), 32'h01A);
        step(); chk("t1_serr_once", 32'(w_out), 32'h018);
        sref(); chk("t1_s4", 32'(w_out), 32'h018);
        sref(); chk("t1_s5_done", 32'(w_out), 32'h004);
        step(); chk("t1_idle", 32'(w_out), 32'h000);
        // start=0 stop=1, every trigger at index 0
        start_cnt = 4'd0; stop_cnt = 4'd1; trig_cnt = 16'h0000;
        go();   chk("t2_arm", 32'(w_out), 32'h008);
        sref(); chk("t2_s0", 32'(w_out), 32'h3F8);
        sref(); chk("t2_s1_done", 32'(w_out), 32'h3C4);
        step(); chk("t2_c3", 32'(w_out), 32'h3C0);
        step(); chk("t2_c4", 32'(w_out), 32'h3C0);
        step(); chk("t2_c5", 32'(w_out), 32'h000);
        // external start: level held 10 cycles, reg_start toggling is ignored
        start_cnt = 4'd1; stop_cnt = 4'd3; trig_cnt = 16'hFFFF; ext_en = 1'b1;
        trig_in = 1'b1;
        step(); chk("t3_arm", 32'(w_out), 32'h008);
        for (int i = 0; i < 9; i++) begin
            reg_start = ~reg_start;
            step(); chk("t3_hold", 32'(w_out), 32'h008);
        end
        trig_in = 1'b0; reg_start = 1'b0;
        sref(); chk("t3_s0", 32'(w_out), 32'h008);
        sref(); chk("t3_s1", 32'(w_out), 32'h038);
        sref(); chk("t3_s2", 32'(w_out), 32'h018);
        sref(); chk("t3_s3_done", 32'(w_out), 32'h004);
        step(); step(); chk("t3_single", 32'(w_out), 32'h000);
        ext_en = 1'b0;
        // invalid window
        start_cnt = 4'd4; stop_cnt = 4'd4;
        go();   chk("t4_cfg_err", 32'(w_out), 32'h001);
        step(); chk("t4_cfg_once", 32'(w_out), 32'h000);
        sref(); chk("t4_no_run", 32'(w_out), 32'h000);
        // abort at sysref #3 with a concurrent start
        start_cnt = 4'd1; stop_cnt = 4'd6; trig_cnt = 16'hFF13;
        go();   chk("t5_arm", 32'(w_out), 32'h008);
        sref(); chk("t5_s0", 32'(w_out), 32'h008);
        sref(); chk("t5_s1", 32'(w_out), 32'h0B8);
        sref(); chk("t5_s2", 32'(w_out), 32'h098);
        sysref = 1'b1; abort = 1'b1; reg_start = 1'b1;
        step();
        sysref = 1'b0; reg_start = 1'b0;
        chk("t5_abort", 32'(w_out), 32'h000);
        step(); chk("t5_abort_start_idle", 32'(w_out), 32'h000);
        abort = 1'b0;
        step(); chk("t5_quiet", 32'(w_out), 32'h000);
        // reset mid-RUN clears outputs without waiting for a clock
        go();
        sref();
        sref(); chk("t6_s1", 32'(w_out), 32'h0B8);
        #2 resetn = 1'b0;
        #1 chk("t6_async", 32'(w_out), 32'h000);
        step();
        resetn = 1'b1;
        step(); chk("t6_after", 32'(w_out), 32'h000);
        sref(); chk("t6_idle", 32'(w_out), 32'h000);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
